// File: rtl/spectrum_peak_detect_pkg.sv
// Shared constants for the spectrum peak detector.
// Contents:
//   DEF_WIDTH, DEF_N   default sample width and bin index width
//   MAG_B1, MAG_B2     shifts forming the 3/8 weight of the smaller component
//   ST_*               FSM state encodings of the frame controller
package spectrum_peak_detect_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_N     = 9;

   // 3/8 = 1/4 + 1/8, realised as two right shifts of min(|re|,|im|)
   localparam int MAG_B1 = 2;
   localparam int MAG_B2 = 3;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;
   localparam logic [1:0] ST_REPORT = 2'd3;

endpackage

// File: rtl/spectrum_peak_detect_mag_approx.sv
// Three-stage approximate magnitude pipeline:
// max(|re|,|im|) + 3/8*min(|re|,|im|), with valid and bin tags carried alongside.
// Ports:
//   clk, areset          clock, asynchronous active-low reset
//   in_valid/bin/re/im   captured sample (signed re/im) and its bin index
//   out_valid            1-clk strobe, 3 clocks after in_valid
//   out_bin, out_mag     bin tag and unsigned magnitude, held until the next strobe
module spectrum_peak_detect_mag_approx
   import spectrum_peak_detect_pkg::*;
#(
   parameter int width = DEF_WIDTH,
   parameter int N     = DEF_N
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             in_valid,
   input  logic [N-1:0]     in_bin,
   input  logic [width-1:0] in_re,
   input  logic [width-1:0] in_im,
   output logic             out_valid,
   output logic [N-1:0]     out_bin,
   output logic [width:0]   out_mag
);

   localparam int MW = width + 1;

   logic [width-1:0] abs_re;
   logic [width-1:0] abs_im;
   logic             s1_valid;
   logic [N-1:0]     s1_bin;
   logic [width-1:0] s1_a;
   logic [width-1:0] s1_b;
   logic             s2_valid;
   logic [N-1:0]     s2_bin;
   logic [width-1:0] s2_mx;
   logic [width-1:0] s2_mn;

   // Negation modulo 2^width: the most negative input maps onto 2^(width-1),
   // which is exactly its magnitude when read as unsigned.
   always_comb begin
      abs_re = in_re[width-1] ? -in_re : in_re;
      abs_im = in_im[width-1] ? -in_im : in_im;
   end

   // Stage 1: absolute values
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         s1_valid <= 1'b0;
         s1_bin   <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_bin <= in_bin;
            s1_a   <= abs_re;
            s1_b   <= abs_im;
         end
      end
   end

   // Stage 2: order the two components
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         s2_valid <= 1'b0;
         s2_bin   <= '0;
         s2_mx    <= '0;
         s2_mn    <= '0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_bin <= s1_bin;
            s2_mx  <= (s1_a > s1_b) ? s1_a : s1_b;
            s2_mn  <= (s1_a > s1_b) ? s1_b : s1_a;
         end
      end
   end

   // Stage 3: weighted sum; one extra bit covers the largest case (1 + 3/8)
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         out_valid <= 1'b0;
         out_bin   <= '0;
         out_mag   <= '0;
      end else begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            out_bin <= s2_bin;
            out_mag <= {1'b0, s2_mx} + MW'(s2_mn >> MAG_B1) + MW'(s2_mn >> MAG_B2);
         end
      end
   end

endmodule

// File: rtl/spectrum_peak_detect.sv
// Per-bin magnitude streamer and frame peak detector, fed by the bit-reverse
// readout stage which replays one FFT frame in natural bin order.
// Ports:
//   clk, areset                 clock, asynchronous active-low reset
//   enout                       upstream readout active
//   cnt_ram_out                 upstream bin index
//   din_re, din_im              upstream sample, valid 1 clk after an index change
//   mag_valid, mag_bin, mag     streamed per-bin magnitude
//   peak_valid, peak_bin, peak_mag   frame maximum, strobed at frame end
//   busy                        controller not idle
//   overrun                     1-clk strobe when a frame start is dropped
module spectrum_peak_detect
   import spectrum_peak_detect_pkg::*;
#(
   parameter int width   = DEF_WIDTH,
   parameter int N       = DEF_N,
   parameter int SETTLE  = 2,
   parameter int SKIP_DC = 1,
   parameter int HALF    = 1
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             enout,
   input  logic [N-1:0]     cnt_ram_out,
   input  logic [width-1:0] din_re,
   input  logic [width-1:0] din_im,
   output logic             mag_valid,
   output logic [N-1:0]     mag_bin,
   output logic [width:0]   mag,
   output logic             peak_valid,
   output logic [N-1:0]     peak_bin,
   output logic [width:0]   peak_mag,
   output logic             busy,
   output logic             overrun
);

   localparam int CW = $clog2(SETTLE + 4) + 1;

   logic             enout_q;
   logic [N-1:0]     cnt_q;
   logic [1:0]       state;
   logic [CW-1:0]    timer;
   logic [CW-1:0]    drain_cnt;
   logic [N-1:0]     pend_bin;
   logic             cap_valid;
   logic [N-1:0]     cap_bin;
   logic [width-1:0] cap_re;
   logic [width-1:0] cap_im;
   logic             enout_rise;
   logic             bin_event;
   logic             accept;
   logic             cap_fire;
   logic             frame_live;
   logic             in_range;

   // Bins are only taken from a frame this controller owns: one already
   // running, or one whose first bin arrives together with the start edge.
   // A frame whose start was dropped keeps enout high but never enters RUN.
   assign enout_rise = enout && !enout_q;
   assign bin_event  = enout && (!enout_q || (cnt_ram_out != cnt_q));
   assign accept     = bin_event && ((state == ST_RUN) || ((state == ST_IDLE) && enout_rise));
   // Requiring enout at capture time discards the brief index wrap to 0
   // that upstream shows just before readout ends.
   assign cap_fire   = (timer == CW'(1)) && enout && (state == ST_RUN);
   assign frame_live = (state == ST_RUN) || (state == ST_DRAIN);
   assign peak_valid = (state == ST_REPORT);
   assign busy       = (state != ST_IDLE);

   // Bins outside the search window are still streamed, just never ranked
   always_comb begin
      in_range = 1'b1;
      if ((SKIP_DC != 0) && (mag_bin == '0)) in_range = 1'b0;
      if ((HALF != 0) && mag_bin[N-1]) in_range = 1'b0;
   end

   // Delayed copies of the upstream handshake for change detection
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         enout_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         enout_q <= enout;
         cnt_q   <= cnt_ram_out;
      end
   end

   // Settle timer: a newer bin event simply reloads it, so only the latest
   // bin ever gets captured. The timer shows 1 exactly SETTLE clocks later.
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         timer    <= '0;
         pend_bin <= '0;
      end else if (accept) begin
         timer    <= CW'(SETTLE);
         pend_bin <= cnt_ram_out;
      end else if (timer != '0) begin
         timer <= timer - CW'(1);
      end
   end

   // Sample capture feeding the magnitude pipeline
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         cap_valid <= 1'b0;
         cap_bin   <= '0;
         cap_re    <= '0;
         cap_im    <= '0;
      end else begin
         cap_valid <= cap_fire;
         if (cap_fire) begin
            cap_bin <= pend_bin;
            cap_re  <= din_re;
            cap_im  <= din_im;
         end
      end
   end

   spectrum_peak_detect_mag_approx #(
      .width (width),
      .N     (N)
   ) u_mag (
      .clk       (clk),
      .areset    (areset),
      .in_valid  (cap_valid),
      .in_bin    (cap_bin),
      .in_re     (cap_re),
      .in_im     (cap_im),
      .out_valid (mag_valid),
      .out_bin   (mag_bin),
      .out_mag   (mag)
   );

   // Frame controller and running maximum. DRAIN lasts long enough for the
   // last capture and its three pipeline stages to land before REPORT.
   // Strict greater-than keeps the lowest index among equal magnitudes.
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         state     <= ST_IDLE;
         drain_cnt <= '0;
         peak_bin  <= '0;
         peak_mag  <= '0;
         overrun   <= 1'b0;
      end else begin
         overrun <= enout_rise && ((state == ST_DRAIN) || (state == ST_REPORT));
         case (state)
            ST_IDLE: begin
               if (enout_rise) begin
                  state    <= ST_RUN;
                  peak_bin <= '0;
                  peak_mag <= '0;
               end
            end
            ST_RUN: begin
               if (!enout) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= CW'(SETTLE + 3);
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == '0) state <= ST_REPORT;
               else drain_cnt <= drain_cnt - CW'(1);
            end
            ST_REPORT: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
         if (frame_live && mag_valid && in_range && (mag > peak_mag)) begin
            peak_mag <= mag;
            peak_bin <= mag_bin;
         end
      end
   end

endmodule

// File: tb/tb_spectrum_peak_detect.sv
// Scoreboard bench for spectrum_peak_detect: an upstream readout model plays
// frames (fdiv=8), expected magnitudes/peaks are queued when issued and a
// monitor compares them against DUT strobes, including their arrival cycle.
module tb_spectrum_peak_detect;

   localparam int W      = 16;
   localparam int NB     = 512;
   localparam int FDIV   = 8;
   localparam int SETTLE = 2;

   typedef struct {
      int bin;
      int val;
      int t;
   } exp_t;

   logic        clk;
   logic        areset;
   logic        enout;
   logic [8:0]  cnt_ram_out;
   logic [15:0] din_re;
   logic [15:0] din_im;
   logic        mag_valid;
   logic [8:0]  mag_bin;
   logic [16:0] mag;
   logic        peak_valid;
   logic [8:0]  peak_bin;
   logic [16:0] peak_mag;
   logic        busy;
   logic        overrun;

   int   checks;
   int   failures;
   int   cyc;
   int   frame_strobes;
   int   fre[NB];
   int   fim[NB];
   exp_t mq[$];
   exp_t pq[$];
   int   oq[$];

   spectrum_peak_detect dut (
      .clk         (clk),
      .areset      (areset),
      .enout       (enout),
      .cnt_ram_out (cnt_ram_out),
      .din_re      (din_re),
      .din_im      (din_im),
      .mag_valid   (mag_valid),
      .mag_bin     (mag_bin),
      .mag         (mag),
      .peak_valid  (peak_valid),
      .peak_bin    (peak_bin),
      .peak_mag    (peak_mag),
      .busy        (busy),
      .overrun     (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Approximate magnitude straight from its definition
   function automatic int ref_mag(input int re, input int im);
      int a;
      int b;
      int mx;
      int mn;
      a  = (re < 0) ? -re : re;
      b  = (im < 0) ? -im : im;
      mx = (a > b) ? a : b;
      mn = (a > b) ? b : a;
      return mx + mn / 4 + mn / 8;
   endfunction

   // Peak search: bins 1..255, first occurrence of the maximum, 0/0 if none above 0
   task automatic ref_peak(output int pb, output int pm);
      int m;
      pb = 0;
      pm = 0;
      for (int b = 1; b < NB / 2; b++) begin
         m = ref_mag(fre[b], fim[b]);
         if (m > pm) begin
            pm = m;
            pb = b;
         end
      end
   endtask

   task automatic fill_random();
      for (int b = 0; b < NB; b++) begin
         fre[b] = int'($urandom_range(0, 65535)) - 32768;
         fim[b] = int'($urandom_range(0, 65535)) - 32768;
      end
   endtask

   task automatic fill_zero();
      for (int b = 0; b < NB; b++) begin
         fre[b] = 0;
         fim[b] = 0;
      end
   endtask

   task automatic check_all_zero();
      check_output("rst_mag_valid", mag_valid, 0);
      check_output("rst_mag_bin", mag_bin, 0);
      check_output("rst_mag", mag, 0);
      check_output("rst_peak_valid", peak_valid, 0);
      check_output("rst_peak_bin", peak_bin, 0);
      check_output("rst_peak_mag", peak_mag, 0);
      check_output("rst_busy", busy, 0);
      check_output("rst_overrun", overrun, 0);
   endtask

   // Upstream readout: index changes after a clock edge, data follows one clock
   // later, each bin held FDIV+1 clocks, then a 1-clk wrap to 0 before enout falls.
   // Expected strobe times use t = first edge sampling the new index.
   task automatic play_frame(input bit do_overrun, input int abort_bin);
      int last_addr;
      int pb;
      int pm;
      last_addr = 0;
      frame_strobes = 0;
      for (int b = 0; b < NB; b++) begin
         for (int h = 0; h <= FDIV; h++) begin
            @(posedge clk);
            #1;
            enout       = 1'b1;
            cnt_ram_out = 9'(b);
            din_re      = 16'(fre[last_addr]);
            din_im      = 16'(fim[last_addr]);
            last_addr   = b;
            if (h == 0) mq.push_back('{b, ref_mag(fre[b], fim[b]), cyc + 1 + SETTLE + 3});
            if (b == abort_bin && h == FDIV) begin
               areset = 1'b0;
               enout  = 1'b0;
               #1;
               check_all_zero();
               repeat (3) @(posedge clk);
               #1;
               areset = 1'b1;
               repeat (30) @(posedge clk);
               check_output("abort_busy", busy, 0);
               return;
            end
         end
      end
      @(posedge clk);
      #1;
      cnt_ram_out = '0;
      din_re      = 16'(fre[last_addr]);
      din_im      = 16'(fim[last_addr]);
      @(posedge clk);
      #1;
      enout  = 1'b0;
      din_re = 16'(fre[0]);
      din_im = 16'(fim[0]);
      ref_peak(pb, pm);
      pq.push_back('{pb, pm, cyc + 1 + SETTLE + 4});
      if (do_overrun) begin
         repeat (2) @(posedge clk);
         #1;
         enout = 1'b1;
         oq.push_back(cyc + 1);
         @(posedge clk);
         #1;
         enout = 1'b0;
      end
      repeat (20) @(posedge clk);
      check_output("frame_strobes", frame_strobes, NB);
      check_output("frame_idle_busy", busy, 0);
   endtask

   // Monitor: every DUT strobe is matched against the head of its queue
   initial begin : monitor
      exp_t e;
      int   ot;
      forever begin
         @(negedge clk);
         if (mag_valid) begin
            frame_strobes++;
            if (mq.size() == 0) check_output("unexpected_mag_valid", 1, 0);
            else begin
               e = mq.pop_front();
               check_output("mag_bin", mag_bin, e.bin);
               check_output("mag_value", mag, e.val);
               check_output("mag_cycle", cyc, e.t);
            end
         end
         if (peak_valid) begin
            if (pq.size() == 0) check_output("unexpected_peak_valid", 1, 0);
            else begin
               e = pq.pop_front();
               check_output("peak_bin", peak_bin, e.bin);
               check_output("peak_mag", peak_mag, e.val);
               check_output("peak_cycle", cyc, e.t);
            end
         end
         if (overrun) begin
            if (oq.size() == 0) check_output("unexpected_overrun", 1, 0);
            else begin
               ot = oq.pop_front();
               check_output("overrun_cycle", cyc, ot);
            end
         end
      end
   end

   initial begin : stimulus
      checks        = 0;
      failures      = 0;
      cyc           = 0;
      frame_strobes = 0;
      areset        = 1'b0;
      enout         = 1'b0;
      cnt_ram_out   = '0;
      din_re        = '0;
      din_im        = '0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero();
      areset = 1'b1;
      repeat (5) @(posedge clk);

      // Random frame with the bin 37 and full-scale bin 5 cases planted
      fill_random();
      fre[37] = 1000;
      fim[37] = -400;
      fre[5]  = -32768;
      fim[5]  = -32768;
      play_frame(1'b0, -1);

      // DC and upper half are excluded; overrun pulse during DRAIN
      fill_zero();
      fre[0]   = 30000;
      fre[100] = 500;
      fre[300] = 9000;
      play_frame(1'b1, -1);

      // Equal magnitudes: lowest index wins
      fill_zero();
      fre[20] = 700;
      fim[40] = -700;
      play_frame(1'b0, -1);

      // Empty frame reports 0/0
      fill_zero();
      play_frame(1'b0, -1);

      fill_random();
      play_frame(1'b0, -1);

      // Reset mid-frame at bin 200, then a clean frame afterwards
      fill_random();
      play_frame(1'b0, 200);
      fill_random();
      play_frame(1'b0, -1);

      repeat (10) @(posedge clk);
      check_output("pending_mag", mq.size(), 0);
      check_output("pending_peak", pq.size(), 0);
      check_output("pending_overrun", oq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
